pipe_ifid_buffer: RTL and testbench

- Consumer end of the instruction-fetch interface. Accepts fetched (inst, pc) pairs from the IF stage and drives the ID stage.
- Returns the fetch write-enable `if_wip` to IF as back-pressure.
- A small FIFO decouples ID stalls from fetch.
- Branch/jump flush discards all buffered instructions.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/ifid_entry_regs.sv | 26 ++
 rtl/pipe_ifid_buffer.sv | 107 ++++++++++
 tb/tb_pipe_ifid_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the IF/ID pipeline boundary.
// Holds the NOP encoding, pc step, default widths and the buffered entry layout.
package pipe_pkg;

    localparam int DEFAULT_PC_W   = 32;
    localparam int DEFAULT_INST_W = 32;

    localparam logic [31:0] INST_NOP = 32'h0000_0000;
    localparam int          PC_STEP  = 4;

    // Field order matches the packed {pc, inst} word stored in the entry file.
    typedef struct packed {
        logic [DEFAULT_PC_W-1:0]   pc;
        logic [DEFAULT_INST_W-1:0] inst;
    } ifid_entry_t;

endpackage

// File: rtl/ifid_entry_regs.sv
// DEPTH x W register file: one synchronous write port, one asynchronous read port.
// Holds the buffered {pc, inst} words of the IF/ID buffer.
module ifid_entry_regs #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: storage is not reset; occupancy in the parent decides which words are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_ifid_buffer.sv
// IF/ID decoupling FIFO: accepts fetched (inst, pc) pairs, drives ID, back-pressures IF via if_wip.
// Optional same-cycle bypass of an empty buffer is enabled by defining IFID_BYPASS_EN.
module pipe_ifid_buffer
    import pipe_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int PC_W   = DEFAULT_PC_W,
    parameter int INST_W = DEFAULT_INST_W
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [INST_W-1:0]        if_inst,
    input  logic [PC_W-1:0]          if_pc,
    input  logic                     if_valid,
    output logic                     if_wip,
    input  logic                     flush,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [INST_W-1:0]        id_inst,
    output logic [PC_W-1:0]          id_pc,
    output logic [PC_W-1:0]          id_pc4,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = PC_W + INST_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   cnt;
    logic [PC_W-1:0] last_pc;
    logic [EW-1:0]   head;
    logic            bypass;
    logic            push, pop, take, wr_en, rd_en;

    ifid_entry_regs #(.DEPTH(DEPTH), .W(EW)) u_regs (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({if_pc, if_inst}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Back-pressure looks only at registered occupancy, never at id_ready.
    assign if_wip = ~clr & (cnt != FULL);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        bypass   = 1'b0;
`ifdef IFID_BYPASS_EN
        bypass   = ~clr & (cnt == '0) & if_valid & ~flush;
`endif
        id_valid = ~clr & ((cnt != '0) | bypass);
        id_inst  = INST_W'(INST_NOP);
        id_pc    = clr ? '0 : last_pc;
        if (bypass) begin
            id_inst = if_inst;
            id_pc   = if_pc;
        end else if (id_valid) begin
            id_inst = head[INST_W-1:0];
            id_pc   = head[EW-1 -: PC_W];
        end
    end

    assign id_pc4 = id_pc + PC_W'(PC_STEP);
    assign count  = cnt;

    assign push  = if_valid & if_wip & ~flush;
    assign pop   = id_valid & id_ready & ~flush;
    // A bypassed entry consumed in the same cycle never touches storage.
    assign take  = bypass & id_ready;
    assign wr_en = push & ~take;
    assign rd_en = pop & ~take;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // The pc shown while empty is the most recently consumed one.
    always_ff @(posedge clk) begin
        if (clr) begin
            last_pc <= '0;
        end else if (pop) begin
            last_pc <= id_pc;
        end
    end

endmodule

// File: tb/tb_pipe_ifid_buffer.sv
// Self-checking bench for pipe_ifid_buffer at DEPTH=2: vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pipe_ifid_buffer;
    import pipe_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        clr, if_valid, flush, id_ready;
    logic [31:0] if_inst, if_pc;
    logic        if_wip, id_valid;
    logic [31:0] id_inst, id_pc, id_pc4;
    logic [1:0]  count;

    int total = 0;
    int bad   = 0;

    pipe_ifid_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .clr      (clr),
        .if_inst  (if_inst),
        .if_pc    (if_pc),
        .if_valid (if_valid),
        .if_wip   (if_wip),
        .flush    (flush),
        .id_ready (id_ready),
        .id_valid (id_valid),
        .id_inst  (id_inst),
        .id_pc    (id_pc),
        .id_pc4   (id_pc4),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic fl, input logic rdy);
        if_valid = v;
        if_inst  = inst;
        if_pc    = pc;
        flush    = fl;
        id_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic wip, input logic val,
                             input logic [31:0] inst, input logic [31:0] pc, input int cnt);
        check({tag, ".if_wip"},   64'(if_wip),   64'(wip));
        check({tag, ".id_valid"}, 64'(id_valid), 64'(val));
        check({tag, ".id_inst"},  64'(id_inst),  64'(inst));
        check({tag, ".id_pc"},    64'(id_pc),    64'(pc));
        check({tag, ".id_pc4"},   64'(id_pc4),   64'(32'(pc + 32'd4)));
        check({tag, ".count"},    64'(count),    64'(cnt));
    endtask

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fl;
        logic        rdy;
        logic        e_wip;
        logic        e_val;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t vt [16];

    // Reference model state: buffered entries in order, plus the last consumed pc.
    ifid_entry_t mq [$];
    logic [31:0] m_last;

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        clr = 1'b1;

        tick();
        tick();
        check_out("reset", 1'b0, 1'b0, 32'h0, 32'h0, 0);
        clr = 1'b0;
        #1;
        check("post_reset.if_wip", 64'(if_wip), 64'd1);

`ifndef IFID_BYPASS_EN
        // Expected values are the outputs seen before the edge that applies the row's inputs.
        vt[0]  = '{1, 32'h20010001, 32'h00, 0, 1, 1, 0, 32'h0,        32'h00, 0};
        vt[1]  = '{1, 32'h20020002, 32'h04, 0, 1, 1, 1, 32'h20010001, 32'h00, 1};
        vt[2]  = '{1, 32'h00221820, 32'h08, 0, 1, 1, 1, 32'h20020002, 32'h04, 1};
        vt[3]  = '{0, 32'h0,        32'h00, 0, 1, 1, 1, 32'h00221820, 32'h08, 1};
        vt[4]  = '{0, 32'h0,        32'h00, 0, 0, 1, 0, 32'h0,        32'h08, 0};
        vt[5]  = '{1, 32'h11111111, 32'h10, 0, 0, 1, 0, 32'h0,        32'h08, 0};
        vt[6]  = '{1, 32'h22222222, 32'h14, 0, 0, 1, 1, 32'h11111111, 32'h10, 1};
        vt[7]  = '{1, 32'h33333333, 32'h18, 0, 0, 0, 1, 32'h11111111, 32'h10, 2};
        vt[8]  = '{1, 32'h33333333, 32'h18, 0, 1, 0, 1, 32'h11111111, 32'h10, 2};
        vt[9]  = '{1, 32'h33333333, 32'h18, 0, 0, 1, 1, 32'h22222222, 32'h14, 1};
        vt[10] = '{0, 32'h0,        32'h00, 0, 0, 0, 1, 32'h22222222, 32'h14, 2};
        vt[11] = '{1, 32'h44444444, 32'h40, 1, 0, 0, 1, 32'h22222222, 32'h14, 2};
        vt[12] = '{0, 32'h0,        32'h00, 0, 0, 1, 0, 32'h0,        32'h10, 0};
        vt[13] = '{1, 32'h55555555, 32'h50, 0, 0, 1, 0, 32'h0,        32'h10, 0};
        vt[14] = '{0, 32'h0,        32'h00, 0, 1, 1, 1, 32'h55555555, 32'h50, 1};
        vt[15] = '{0, 32'h0,        32'h00, 0, 0, 1, 0, 32'h0,        32'h50, 0};

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].v, vt[i].inst, vt[i].pc, vt[i].fl, vt[i].rdy);
            #3;
            check_out($sformatf("vec%0d", i), vt[i].e_wip, vt[i].e_val,
                      vt[i].e_inst, vt[i].e_pc, vt[i].e_cnt);
            tick();
        end

        // Continuous push+pop across several pointer wraps.
        for (int k = 0; k < 6; k++) begin
            drive(k < 5, 32'hA000_0000 + 32'(k), 32'h100 + 32'(4 * k), 1'b0, 1'b1);
            #3;
            if (k == 0)
                check_out("wrap0", 1'b1, 1'b0, 32'h0, 32'h50, 0);
            else
                check_out($sformatf("wrap%0d", k), 1'b1, 1'b1,
                          32'hA000_0000 + 32'(k - 1), 32'h100 + 32'(4 * (k - 1)), 1);
            tick();
        end

        // pc4 wraps modulo 2^32 at the top of the address space.
        drive(1'b1, 32'hDEADBEEF, 32'hFFFF_FFFC, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        #3;
        check("top_pc.id_pc",  64'(id_pc),  64'h0000_0000_FFFF_FFFC);
        check("top_pc.id_pc4", 64'(id_pc4), 64'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #3;
        check("top_pc.drained", 64'(id_valid), 64'd0);
`else
        // Empty buffer with a consuming ID stage: same-cycle pass-through, nothing stored.
        drive(1'b1, 32'h8C220000, 32'h20, 1'b0, 1'b1);
        #3;
        check("bypass.id_valid", 64'(id_valid), 64'd1);
        check("bypass.id_inst",  64'(id_inst),  64'h8C220000);
        check("bypass.id_pc",    64'(id_pc),    64'h20);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #3;
        check("bypass.count",    64'(count),    64'd0);
        check("bypass.id_valid_after", 64'(id_valid), 64'd0);
`endif

        // Randomized traffic; first cycle is a reset so the model starts in step.
        for (int c = 0; c < 400; c++) begin
            logic        r_clr, exp_wip, exp_val, byp;
            logic [31:0] exp_inst, exp_pc;
            ifid_entry_t hd;
            r_clr = (c == 0) || ($urandom_range(0, 39) == 0);
            clr   = r_clr;
            drive($urandom_range(0, 3) != 0, $urandom, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
            #3;
            byp = 1'b0;
`ifdef IFID_BYPASS_EN
            byp = !r_clr && mq.size() == 0 && if_valid && !flush;
`endif
            exp_wip  = !r_clr && mq.size() != DEPTH;
            exp_val  = !r_clr && (mq.size() != 0 || byp);
            hd       = byp ? ifid_entry_t'{pc: if_pc, inst: if_inst}
                           : (mq.size() != 0 ? mq[0] : ifid_entry_t'('0));
            exp_inst = exp_val ? hd.inst : INST_NOP;
            exp_pc   = r_clr ? 32'h0 : (exp_val ? hd.pc : m_last);
            if (c >= 1) begin
                check_out($sformatf("rnd%0d", c), exp_wip, exp_val, exp_inst, exp_pc, mq.size());
            end
            if (r_clr) begin
                mq.delete();
                m_last = 32'h0;
            end else if (flush) begin
                mq.delete();
            end else if (byp && id_ready) begin
                m_last = if_pc;
            end else begin
                if (exp_val && id_ready) begin
                    m_last = mq[0].pc;
                    void'(mq.pop_front());
                end
                if (if_valid && exp_wip) mq.push_back('{pc: if_pc, inst: if_inst});
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
